cla_word_sequencer: RTL

Multi-cycle wide adder/subtractor that reuses one `nBitCarryLookAheadAdder` word-serially. It captures full-width operands on `start` and feeds the adder one `NUMBITS` slice per cycle, LSB word first, with the carry held in a register between slices. It then presents a `NUMWORDS*NUMBITS`-bit result with carry and signed overflow. It sits in front of the CLA datapath wherever operands wider than the instantiated adder are needed.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_word_sequencer_if.sv | 37 +++
 rtl/nBitCarryLookAheadAdder.sv | 54 +++++
 rtl/cla_word_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the carry-lookahead datapath and its word-serial
// sequencer.
//   BASEADDERSIZE   - width of one lookahead group inside the CLA
//   cla_seq_state_t - control states of the word sequencer
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int BASEADDERSIZE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cla_seq_state_t;

endpackage

// File: rtl/cla_word_sequencer_if.sv
// -----------------------------------------------------------------------------
// cla_word_sequencer_if
// Request/result bundle of the word-serial adder/subtractor.
//   start, sub, a_in, b_in          - request side (driven by the master)
//   busy, done, s_out, c_out, ovf   - status and result (driven by the slave)
// Modports:
//   master - the client issuing operations
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface cla_word_sequencer_if #(
  parameter int NUMBITS  = 8,
  parameter int NUMWORDS = 4
);

  localparam int W = NUMBITS * NUMWORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         c_out;
  logic         ovf;

  modport master (
    output start, sub, a_in, b_in,
    input  busy, done, s_out, c_out, ovf
  );

  modport slave (
    input  start, sub, a_in, b_in,
    output busy, done, s_out, c_out, ovf
  );

endinterface

// File: rtl/nBitCarryLookAheadAdder.sv
// -----------------------------------------------------------------------------
// nBitCarryLookAheadAdder
// Purely combinational NUMBITS-wide adder built from 4-bit lookahead groups;
// group carries ripple from one group to the next.
// Ports:
//   a, b   in  NUMBITS  addends
//   c_in   in  1        carry into bit 0
//   sum    out NUMBITS  a + b + c_in
//   c_out  out 1        carry out of the top bit
// -----------------------------------------------------------------------------
module nBitCarryLookAheadAdder
  import cla_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               c_in,
  output logic [NUMBITS-1:0] sum,
  output logic               c_out
);

  localparam int NUMGROUPS = NUMBITS / BASEADDERSIZE;

  logic [NUMGROUPS:0] group_carry;

  assign group_carry[0] = c_in;

  // Each group resolves all four internal carries in two logic levels from
  // its generate/propagate terms; only the group carry-out travels onward.
  for (genvar g = 0; g < NUMGROUPS; g++) begin : g_group
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    assign gen  = a[g*BASEADDERSIZE +: BASEADDERSIZE] & b[g*BASEADDERSIZE +: BASEADDERSIZE];
    assign prop = a[g*BASEADDERSIZE +: BASEADDERSIZE] ^ b[g*BASEADDERSIZE +: BASEADDERSIZE];

    assign c[0] = group_carry[g];
    assign c[1] = gen[0] | (prop[0] & c[0]);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c[0]);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & c[0]);
    assign c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & c[0]);

    assign sum[g*BASEADDERSIZE +: BASEADDERSIZE] = prop ^ c[3:0];
    assign group_carry[g+1] = c[4];
  end

  assign c_out = group_carry[NUMGROUPS];

endmodule

// File: rtl/cla_word_sequencer.sv
// -----------------------------------------------------------------------------
// cla_word_sequencer
// Wide adder/subtractor that pushes NUMWORDS slices of NUMBITS bits, LSB
// slice first, through a single NUMBITS-wide CLA, holding the carry in a
// register between slices.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous, active-high reset
//   bus    slave   request (start/sub/a_in/b_in) and result
//                  (busy/done/s_out/c_out/ovf), W = NUMWORDS*NUMBITS
// -----------------------------------------------------------------------------
module cla_word_sequencer
  import cla_pkg::*;
#(
  parameter int NUMBITS  = 8,
  parameter int NUMWORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cla_word_sequencer_if.slave  bus
);

  localparam int W  = NUMBITS * NUMWORDS;
  localparam int KW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;

  // Reject slice widths the 4-bit lookahead groups cannot tile, and an
  // empty word count, while elaborating.
  if ((NUMBITS % BASEADDERSIZE) != 0 || NUMWORDS < 1) begin : g_bad_params
    $error("cla_word_sequencer: NUMBITS must be a multiple of 4 and NUMWORDS >= 1");
  end

  cla_seq_state_t state_q;
  cla_seq_state_t state_d;

  logic [KW-1:0]      k_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       acc_merge;
  logic [W-1:0]       s_q;
  logic               c_q;
  logic               ovf_q;

  logic [NUMBITS-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;
  logic               accept;

  assign last_slice = (k_q == KW'(NUMWORDS - 1));
  assign accept     = bus.start && (state_q != RUN);

  nBitCarryLookAheadAdder #(
    .NUMBITS (NUMBITS)
  ) u_adder (
    .a     (a_q[k_q*NUMBITS +: NUMBITS]),
    .b     (b_q[k_q*NUMBITS +: NUMBITS]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Next-state logic: a request is taken from IDLE or straight out of DONE,
  // so back-to-back operations never pass through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The accumulator with the current slice dropped in; on the last slice
  // this is the complete result and goes straight to s_out.
  always_comb begin
    acc_merge = acc_q;
    acc_merge[k_q*NUMBITS +: NUMBITS] = slice_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: subtract is a + ~b + 1, so the operand is inverted once at
  // capture and the carry register is seeded with the mode. Result
  // registers only move on the final slice so the previous result stays
  // visible for the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a_in;
      b_q     <= bus.sub ? ~bus.b_in : bus.b_in;
      carry_q <= bus.sub;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_merge;
      carry_q <= slice_cout;
      k_q     <= k_q + KW'(1);
      if (last_slice) begin
        s_q   <= acc_merge;
        c_q   <= slice_cout;
        ovf_q <= (a_q[W-1] == b_q[W-1]) && (slice_sum[NUMBITS-1] != a_q[W-1]);
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.s_out = s_q;
  assign bus.c_out = c_q;
  assign bus.ovf   = ovf_q;

endmodule
